// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared types and constants for the load/store unit: FSM state
//             encoding, funct3 access codes, datapath widths and a funct3
//             legality helper.
//  Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

    localparam int XLEN  = 32;
    localparam int BE_W  = 4;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic lsu_f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit_if
//  Purpose  : Data-memory bus between the load/store unit (master) and a
//             handshaked memory or peripheral (slave).
//  Ports    : bus_req/bus_we/bus_addr/bus_wdata/bus_be  master -> slave
//             bus_ack/bus_rdata/bus_err                 slave  -> master
//  Revision : 1.0  initial release
// ============================================================================
interface load_store_unit_if;
    import lsu_pkg::*;

    logic                 bus_req;
    logic                 bus_we;
    logic [XLEN-1:0]      bus_addr;
    logic [XLEN-1:0]      bus_wdata;
    logic [BE_W-1:0]      bus_be;
    logic                 bus_ack;
    logic [XLEN-1:0]      bus_rdata;
    logic                 bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_rdata, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_rdata, bus_err
    );

endinterface
`default_nettype wire

// File: rtl/load_store_unit_load_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_load_align
//  Purpose  : Selects the addressed byte/halfword lane of a read word and
//             sign- or zero-extends it according to funct3.
//  Ports    : i_rdata      read word captured from the bus
//             i_addr_lo    byte offset within the word
//             i_funct3     access size / signedness
//             o_load_data  extended result (0 for unsupported funct3)
//  Revision : 1.0  initial release
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
(
    input  wire logic [XLEN-1:0] i_rdata,
    input  wire logic [1:0]      i_addr_lo,
    input  wire logic [2:0]      i_funct3,
    output logic      [XLEN-1:0] o_load_data
);

    // Bring the addressed lane down to bit 0 before extending.
    logic [XLEN-1:0] w_shifted;
    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        o_load_data = '0;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    o_load_data = i_rdata;
            F3_BU:   o_load_data = {24'd0, w_shifted[7:0]};
            F3_HU:   o_load_data = {16'd0, w_shifted[15:0]};
            default: o_load_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Multi-cycle load/store unit between the CPU datapath and a
//             req/ack data-memory bus. Stalls the CPU while an access is in
//             flight and returns the extended load value in DONE.
//  Ports    : clock, reset                    clock / sync active-high reset
//             mem_read, mem_write, funct3,
//             addr, store_data                CPU request
//             load_data, stall,
//             misaligned, access_fault        CPU response
//             bus                             data-memory bus (master side)
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)(
    input  wire logic            clock,
    input  wire logic            reset,
    input  wire logic            mem_read,
    input  wire logic            mem_write,
    input  wire logic [2:0]      funct3,
    input  wire logic [XLEN-1:0] addr,
    input  wire logic [XLEN-1:0] store_data,
    output logic      [XLEN-1:0] load_data,
    output logic                 stall,
    output logic                 misaligned,
    output logic                 access_fault,
    load_store_unit_if.master    bus
);

    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT_CYCLES);

    lsu_state_t        r_state, w_state_next;
    logic [CNT_W-1:0]  r_count;
    logic [XLEN-1:0]   r_rdata;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [BE_W-1:0]   r_be;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;
    logic              r_misaligned;
    logic              r_fault;

    logic              w_req;
    logic              w_legal;
    logic              w_misal;
    logic [BE_W-1:0]   w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [CNT_W-1:0]  w_count_inc;
    logic              w_timeout;
    logic              w_done;
    logic [XLEN-1:0]   w_aligned;

    assign w_req   = mem_read | mem_write;
    assign w_legal = lsu_f3_legal(funct3);
    assign w_misal = w_legal &&
                     (((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)));

    // Store lane placement; loads always fetch the whole word.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = store_data;
        if (mem_write) begin
            case (funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << addr[1:0];
                    w_wdata = {4{store_data[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << {addr[1], 1'b0};
                    w_wdata = {2{store_data[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = store_data;
                end
            endcase
        end
    end

    // The DONE decision looks at the post-increment count so that exactly
    // TIMEOUT_CYCLES REQ cycles elapse before the abort.
    assign w_count_inc = r_count + 1'b1;
    assign w_timeout   = (w_count_inc == c_timeout);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_state_next = (!w_legal || w_misal) ? DONE : REQ;
                end
            end
            REQ: begin
                if (bus.bus_ack || w_timeout) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_rdata      <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_we         <= 1'b0;
            r_funct3     <= '0;
            r_addr_lo    <= '0;
            r_misaligned <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_misaligned <= w_misal;
                        r_fault      <= !w_legal;
                        r_count      <= '0;
                        // Bus-facing registers only move for accesses that
                        // actually reach the bus.
                        if (w_legal && !w_misal) begin
                            r_addr    <= {addr[XLEN-1:2], 2'b00};
                            r_we      <= mem_write;
                            r_be      <= w_be;
                            r_wdata   <= w_wdata;
                            r_funct3  <= funct3;
                            r_addr_lo <= addr[1:0];
                        end
                    end
                end
                REQ: begin
                    if (bus.bus_ack) begin
                        r_rdata <= bus.bus_rdata;
                        r_fault <= bus.bus_err;
                    end else begin
                        r_count <= w_count_inc;
                        if (w_timeout) begin
                            r_fault <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    lsu_load_align u_load_align (
        .i_rdata     (r_rdata),
        .i_addr_lo   (r_addr_lo),
        .i_funct3    (r_funct3),
        .o_load_data (w_aligned)
    );

    // All outputs are forced low while reset is asserted.
    assign w_done       = (r_state == DONE) && !reset;
    assign stall        = w_req && (r_state != DONE) && !reset;
    assign misaligned   = w_done && r_misaligned;
    assign access_fault = w_done && r_fault;
    assign load_data    = (w_done && !r_we && !r_fault && !r_misaligned) ? w_aligned : '0;

    assign bus.bus_req   = (r_state == REQ) && !reset;
    assign bus.bus_we    = r_we & !reset;
    assign bus.bus_addr  = reset ? '0 : r_addr;
    assign bus.bus_wdata = reset ? '0 : r_wdata;
    assign bus.bus_be    = reset ? '0 : r_be;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Self-checking bench for load_store_unit: directed accesses plus
//             randomized loads/stores against a behavioural access model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int TMO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        stall;
    logic        misaligned;
    logic        access_fault;

    load_store_unit_if bus_if ();

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock        (clock),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .addr         (addr),
        .store_data   (store_data),
        .load_data    (load_data),
        .stall        (stall),
        .misaligned   (misaligned),
        .access_fault (access_fault),
        .bus          (bus_if.master)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit f3_ok(input logic [2:0] f);
        return (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5);
    endfunction

    function automatic int unsigned size_of(input logic [2:0] f);
        return 1 << f[1:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f);
        logic [31:0] b, h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (8 * (a % 4))) & 32'hFFFF;
        case (f)
            3'd0:    return (b >= 128)   ? b - 32'd256   : b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_be(input bit wr, input logic [2:0] f, input logic [31:0] a);
        if (!wr || f == 3'd2) return 32'hF;
        if (f == 3'd0) return 32'd1 << (a % 4);
        return ((a % 4) == 2) ? 32'hC : 32'h3;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f, input logic [31:0] d);
        if (f == 3'd0) return (d & 32'hFF) * 32'h01010101;
        if (f == 3'd1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    // ack_at: REQ cycle (1-based) in which the slave acks; 0 = never.
    task automatic access(input bit rd, input bit wr, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] d,
                          input int ack_at, input bit err,
                          input logic [31:0] rword, input string tag);
        bit          legal, mis, on_bus, acked, exp_fault, done;
        int          exp_req, nstall, nreq;
        logic [31:0] exp_ld;

        legal     = f3_ok(f);
        mis       = legal && ((a % size_of(f)) != 0);
        on_bus    = legal && !mis;
        acked     = on_bus && (ack_at >= 1) && (ack_at <= TMO);
        exp_req   = !on_bus ? 0 : (acked ? ack_at : TMO);
        exp_fault = !legal || (on_bus && (!acked || err));
        exp_ld    = (!wr && acked && !err) ? model_load(rword, a, f) : 32'd0;

        mem_read = rd; mem_write = wr; funct3 = f; addr = a; store_data = d;
        bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0;
        nstall = 0; nreq = 0; done = 1'b0;

        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clock);
            if (bus_if.bus_req) begin
                nreq++;
                chk_val({tag, "_addr"}, bus_if.bus_addr, a & 32'hFFFF_FFFC);
                chk_val({tag, "_be"}, {28'd0, bus_if.bus_be}, model_be(wr, f, a));
                chk_val({tag, "_we"}, {31'd0, bus_if.bus_we}, {31'd0, wr});
                if (wr) chk_val({tag, "_wdata"}, bus_if.bus_wdata, model_wdata(f, d));
                if (nreq == ack_at) begin
                    bus_if.bus_ack = 1'b1; bus_if.bus_err = err; bus_if.bus_rdata = rword;
                end else begin
                    bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'($urandom); bus_if.bus_rdata = $urandom;
                end
            end else begin
                bus_if.bus_ack = 1'b0;
            end
            if (stall) begin
                nstall++;
                chk_val({tag, "_ld_busy"}, load_data, 32'd0);
            end else begin
                done = 1'b1;
                chk_val({tag, "_misaligned"}, {31'd0, misaligned}, {31'd0, mis});
                chk_val({tag, "_fault"}, {31'd0, access_fault}, {31'd0, exp_fault});
                chk_val({tag, "_load_data"}, load_data, exp_ld);
            end
        end
        chk_val({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        chk_val({tag, "_stall_cycles"}, nstall, 1 + exp_req);
        chk_val({tag, "_req_cycles"}, nreq, exp_req);

        // CPU moves on; a stray ack while idle must have no effect.
        @(posedge clock); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        bus_if.bus_ack = 1'($urandom); bus_if.bus_err = 1'($urandom);
        @(negedge clock);
        chk_val({tag, "_idle_out"},
                {load_data[30:0] | {27'd0, stall, misaligned, access_fault, bus_if.bus_req}, load_data[31]},
                32'd0);
        @(posedge clock); #1;
        bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0;
    endtask

    initial begin
        logic [2:0]  f;
        logic [2:0]  wr_f3 [6];
        bit          rd, wr;

        wr_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

        reset = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_W;
        addr = 32'h10; store_data = 32'd0;
        bus_if.bus_ack = 1'b1; bus_if.bus_err = 1'b0; bus_if.bus_rdata = 32'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_val("rst_stall", {31'd0, stall}, 32'd0);
        chk_val("rst_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
        chk_val("rst_load_data", load_data, 32'd0);
        chk_val("rst_faults", {30'd0, misaligned, access_fault}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0; mem_read = 1'b0; bus_if.bus_ack = 1'b0;
        @(posedge clock); #1;

        // Directed cases
        access(0, 1, F3_W,  32'h10, 32'hDEADBEEF, 1, 0, 32'h0,        "sw");
        access(1, 0, F3_B,  32'h23, 32'h0,        3, 0, 32'h80112233, "lb");
        access(1, 0, F3_HU, 32'h22, 32'h0,        1, 0, 32'h8001ABCD, "lhu");
        access(0, 1, F3_H,  32'h22, 32'h00001234, 1, 0, 32'h0,        "sh");
        access(1, 0, F3_W,  32'h06, 32'h0,        1, 0, 32'h12345678, "lw_mis");
        access(1, 0, F3_W,  32'h100, 32'h0,       0, 0, 32'h12345678, "lw_tmo");
        access(1, 0, F3_B,  32'h101, 32'h0,       2, 1, 32'h55667788, "lb_err");
        access(1, 0, 3'd3,  32'h40, 32'h0,        1, 0, 32'h0,        "illegal");
        access(1, 1, F3_W,  32'h44, 32'hCAFEF00D, 1, 0, 32'h11111111, "rd_wr");
        access(1, 0, F3_W,  32'h48, 32'h0,        TMO, 0, 32'hA5A5A5A5, "lw_lastack");

        // Reset during REQ, followed by a stray ack
        mem_read = 1'b1; funct3 = F3_W; addr = 32'h80;
        @(negedge clock);
        @(negedge clock);
        chk_val("rstreq_in_req", {31'd0, bus_if.bus_req}, 32'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        chk_val("rstreq_outs", {28'd0, stall, misaligned, access_fault, bus_if.bus_req}, 32'd0);
        chk_val("rstreq_ld", load_data, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0; mem_read = 1'b0; bus_if.bus_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk_val("rstreq_after", {28'd0, stall, misaligned, access_fault, bus_if.bus_req}, 32'd0);
            chk_val("rstreq_after_ld", load_data, 32'd0);
        end
        @(posedge clock); #1;
        bus_if.bus_ack = 1'b0;

        // Randomized accesses
        for (int n = 0; n < 150; n++) begin
            rd = 1'($urandom); wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            f = wr ? wr_f3[$urandom_range(0, 5)] : 3'($urandom);
            access(rd, wr, f, $urandom, $urandom, int'($urandom_range(0, TMO + 1)),
                   ($urandom_range(0, 3) == 0), $urandom, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
